// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: opcodes, functs,
// FSM states, datapath mux selects and exception vectors.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [7:0] EXC_VEC_OPC = 8'd253;
  localparam logic [7:0] EXC_VEC_OVF = 8'd254;

  // R-type ALU ops get their own execute state so alu_op stays a function of state alone
  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_EXEC_ADD  = 5'd3,
    S_EXEC_SUB  = 5'd4,
    S_EXEC_AND  = 5'd5,
    S_EXEC_SLT  = 5'd6,
    S_WB_R      = 5'd7,
    S_JR        = 5'd8,
    S_EXEC_I    = 5'd9,
    S_WB_I      = 5'd10,
    S_ADDR_LW   = 5'd11,
    S_ADDR_SW   = 5'd12,
    S_MEM_RD    = 5'd13,
    S_WB_LW     = 5'd14,
    S_MEM_WR    = 5'd15,
    S_BRANCH_EQ = 5'd16,
    S_BRANCH_NE = 5'd17,
    S_LUI       = 5'd18,
    S_JUMP      = 5'd19,
    S_JAL       = 5'd20,
    S_EXC_OPC   = 5'd21,
    S_EXC_OVF   = 5'd22
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_SLT    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_REG    = 2'd0,
    SRC_B_FOUR   = 2'd1,
    SRC_B_IMM    = 2'd2,
    SRC_B_IMM_SH = 2'd3
  } src_b_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2,
    DST_SP = 2'd3
  } reg_dst_t;

  typedef enum logic [2:0] {
    M2R_ALUOUT = 3'd0,
    M2R_MDR    = 3'd1,
    M2R_PC     = 3'd2,
    M2R_IMM_HI = 3'd3,
    M2R_SP     = 3'd4
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2,
    PCS_EXC    = 2'd3
  } pc_source_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic logic [7:0] exc_vector(input logic cause);
    return cause ? EXC_VEC_OVF : EXC_VEC_OPC;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait-state down-counter: loads a wait count, counts to zero, flags done.
module mem_wait_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS-subset datapath with parametrised
// memory wait states and precise bad-opcode / overflow exceptions.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned SP_INIT  = 227
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic [1:0] pc_source,
  output logic       exc_cause,
  output logic [4:0] state_dbg
);

  if (MEM_WAIT > 15) begin : g_param_check
    $error("multicycle_ctrl: MEM_WAIT=%0d exceeds 4-bit wait counter (SP_INIT=%0d)",
           MEM_WAIT, SP_INIT);
  end

  state_t state;
  state_t state_next;
  logic   wait_done;
  logic   wait_load;

  // Branch condition gating on zero happens in the datapath.
  logic   unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  assign wait_load = is_wait_state(state_next) && (state_next != state);

  mem_wait_timer #(
    .WIDTH (4)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (wait_load),
    .load_val (4'(MEM_WAIT)),
    .done     (wait_done)
  );

  always_comb begin
    state_next = S_RESET;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD:  state_next = S_EXEC_ADD;
              FN_SUB:  state_next = S_EXEC_SUB;
              FN_AND:  state_next = S_EXEC_AND;
              FN_SLT:  state_next = S_EXEC_SLT;
              FN_JR:   state_next = S_JR;
              default: state_next = S_EXC_OPC;
            endcase
          end
          OP_ADDI: state_next = S_EXEC_I;
          OP_LW:   state_next = S_ADDR_LW;
          OP_SW:   state_next = S_ADDR_SW;
          OP_BEQ:  state_next = S_BRANCH_EQ;
          OP_BNE:  state_next = S_BRANCH_NE;
          OP_LUI:  state_next = S_LUI;
          OP_J:    state_next = S_JUMP;
          OP_JAL:  state_next = S_JAL;
          default: state_next = S_EXC_OPC;
        endcase
      end
      S_EXEC_ADD, S_EXEC_SUB: state_next = overflow ? S_EXC_OVF : S_WB_R;
      S_EXEC_AND, S_EXEC_SLT: state_next = S_WB_R;
      S_EXEC_I:  state_next = overflow ? S_EXC_OVF : S_WB_I;
      S_ADDR_LW: state_next = S_MEM_RD;
      S_ADDR_SW: state_next = S_MEM_WR;
      S_MEM_RD:  state_next = wait_done ? S_WB_LW : S_MEM_RD;
      S_MEM_WR:  state_next = wait_done ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_LW, S_JR, S_BRANCH_EQ, S_BRANCH_NE,
      S_LUI, S_JUMP, S_JAL, S_EXC_OPC, S_EXC_OVF: state_next = S_FETCH;
      default:   state_next = S_RESET;
    endcase
  end

  // Outputs are held at zero while reset is asserted so no strobe survives the
  // assertion edge; the RESET state's SP write happens in the first released cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    pc_source     = PCS_ALU;
    exc_cause     = 1'b0;
    if (!reset) begin
      case (state)
        S_RESET: begin
          reg_write  = 1'b1;
          reg_dst    = DST_SP;
          mem_to_reg = M2R_SP;
        end
        S_FETCH: begin
          if (wait_done) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
            pc_source = PCS_ALU;
          end
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM_SH;
          alu_op    = ALU_ADD;
        end
        S_EXEC_ADD: alu_src_a = 1'b1;
        S_EXEC_SUB: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
        end
        S_EXEC_AND: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_AND;
        end
        S_EXEC_SLT: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SLT;
        end
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RD;
          mem_to_reg = M2R_ALUOUT;
        end
        S_JR: begin
          alu_src_a = 1'b1;
          pc_source = PCS_ALU;
          pc_write  = 1'b1;
        end
        S_EXEC_I, S_ADDR_LW, S_ADDR_SW: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          reg_dst   = DST_RT;
        end
        S_MEM_RD: iord = 1'b1;
        S_WB_LW: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RT;
          mem_to_reg = M2R_MDR;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_BRANCH_EQ, S_BRANCH_NE: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          branch_ne     = (state == S_BRANCH_NE);
        end
        S_LUI: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RT;
          mem_to_reg = M2R_IMM_HI;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
        end
        S_EXC_OPC, S_EXC_OVF: begin
          epc_write = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_SUB;
          pc_write  = 1'b1;
          pc_source = PCS_EXC;
          exc_cause = (state == S_EXC_OVF);
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl at MEM_WAIT=1 and MEM_WAIT=3.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam logic [5:0] E_PCW = 6'b100000;
  localparam logic [5:0] E_PCC = 6'b010000;
  localparam logic [5:0] E_MW  = 6'b001000;
  localparam logic [5:0] E_IR  = 6'b000100;
  localparam logic [5:0] E_RW  = 6'b000010;
  localparam logic [5:0] E_EPC = 6'b000001;

  localparam logic [15:0] F_BNE  = 16'h8000;
  localparam logic [15:0] F_IORD = 16'h4000;
  localparam logic [15:0] F_ASA  = 16'h2000;
  localparam logic [15:0] F_ASB  = 16'h1800;
  localparam logic [15:0] F_AOP  = 16'h0700;
  localparam logic [15:0] F_RD   = 16'h00C0;
  localparam logic [15:0] F_M2R  = 16'h0038;
  localparam logic [15:0] F_PCS  = 16'h0006;
  localparam logic [15:0] F_EXC  = 16'h0001;
  localparam logic [15:0] F_ALL  = 16'hFFFF;

  typedef struct {
    string       tag;
    logic [4:0]  st;
    logic [5:0]  en;
    logic [15:0] sv;
    logic [15:0] sm;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic       clock = 1'b0;
  logic       reset1, reset3;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       use3;

  logic [4:0]  st1, st3, obs_st;
  logic [5:0]  en1, en3, obs_en;
  logic [15:0] sel1, sel3, obs_sel;

  initial forever #5 clock = ~clock;

  multicycle_ctrl #(.MEM_WAIT(1), .SP_INIT(227)) dut1 (
    .clock(clock), .reset(reset1), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow),
    .pc_write(en1[5]), .pc_write_cond(en1[4]), .mem_write(en1[3]),
    .ir_write(en1[2]), .reg_write(en1[1]), .epc_write(en1[0]),
    .branch_ne(sel1[15]), .iord(sel1[14]), .alu_src_a(sel1[13]),
    .alu_src_b(sel1[12:11]), .alu_op(sel1[10:8]), .reg_dst(sel1[7:6]),
    .mem_to_reg(sel1[5:3]), .pc_source(sel1[2:1]), .exc_cause(sel1[0]),
    .state_dbg(st1)
  );

  multicycle_ctrl #(.MEM_WAIT(3), .SP_INIT(227)) dut3 (
    .clock(clock), .reset(reset3), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow),
    .pc_write(en3[5]), .pc_write_cond(en3[4]), .mem_write(en3[3]),
    .ir_write(en3[2]), .reg_write(en3[1]), .epc_write(en3[0]),
    .branch_ne(sel3[15]), .iord(sel3[14]), .alu_src_a(sel3[13]),
    .alu_src_b(sel3[12:11]), .alu_op(sel3[10:8]), .reg_dst(sel3[7:6]),
    .mem_to_reg(sel3[5:3]), .pc_source(sel3[2:1]), .exc_cause(sel3[0]),
    .state_dbg(st3)
  );

  always_comb begin
    obs_st  = use3 ? st3  : st1;
    obs_en  = use3 ? en3  : en1;
    obs_sel = use3 ? sel3 : sel1;
  end

  function automatic logic [15:0] v(input logic bne, input logic io, input logic asa,
                                    input logic [1:0] asb, input logic [2:0] aop,
                                    input logic [1:0] rd, input logic [2:0] m2r,
                                    input logic [1:0] pcs, input logic exc);
    return {bne, io, asa, asb, aop, rd, m2r, pcs, exc};
  endfunction

  task automatic push(input string tag, input state_t st, input logic [5:0] en,
                      input logic [15:0] sv, input logic [15:0] sm);
    exp_t e;
    e.tag = tag; e.st = st; e.en = en; e.sv = sv; e.sm = sm;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (obs_st === e.st) else begin
      miscompares++;
      $error("FAIL %s state observed=%0d expected=%0d", e.tag, obs_st, e.st);
    end
    vectors++;
    assert (obs_en === e.en) else begin
      miscompares++;
      $error("FAIL %s enables(pcw,pcc,mw,ir,rw,epc) observed=%b expected=%b", e.tag, obs_en, e.en);
    end
    vectors++;
    assert ((obs_sel & e.sm) === e.sv) else begin
      miscompares++;
      $error("FAIL %s selects observed=%h expected=%h (mask %h)", e.tag, obs_sel & e.sm, e.sv, e.sm);
    end
  endtask

  // One expectation per clock cycle, sampled on the falling edge.
  task automatic chk(input string tag, input state_t st, input logic [5:0] en,
                     input logic [15:0] sv, input logic [15:0] sm);
    push(tag, st, en, sv, sm);
    @(negedge clock);
    compare_front();
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n - 1; i++) chk("fetch_wait", S_FETCH, '0, '0, F_IORD);
    chk("fetch_last", S_FETCH, E_PCW | E_IR, v(0,0,0,2'd1,3'd0,2'd0,3'd0,2'd0,0),
        F_IORD | F_ASA | F_ASB | F_AOP | F_PCS);
  endtask

  task automatic dec();
    chk("decode", S_DECODE, '0, v(0,0,0,2'd3,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic ov, input int n);
    opcode = op; funct = fn; zero = z; overflow = ov;
    fetch(n);
    dec();
  endtask

  initial begin
    reset1 = 1'b1; reset3 = 1'b1; use3 = 1'b0;
    opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

    chk("in_reset1", S_RESET, '0, '0, F_ALL);
    @(posedge clock); #1 reset1 = 1'b0;
    chk("rst_cycle0", S_RESET, E_RW, v(0,0,0,2'd0,3'd0,2'd3,3'd4,2'd0,0), F_RD | F_M2R);

    instr(6'h00, 6'h20, 1'b0, 1'b1, 2);
    chk("exec_add_ovf", S_EXEC_ADD, '0, v(0,0,1,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    chk("exc_ovf", S_EXC_OVF, E_PCW | E_EPC, v(0,0,0,2'd1,3'd1,2'd0,3'd0,2'd3,1),
        F_ASA | F_ASB | F_AOP | F_PCS | F_EXC);

    instr(6'h3F, 6'h00, 1'b0, 1'b0, 2);
    chk("exc_badop", S_EXC_OPC, E_PCW | E_EPC, v(0,0,0,2'd1,3'd1,2'd0,3'd0,2'd3,0),
        F_ASA | F_ASB | F_AOP | F_PCS | F_EXC);

    instr(6'h05, 6'h00, 1'b0, 1'b0, 2);
    chk("bne", S_BRANCH_NE, E_PCC, v(1,0,1,2'd0,3'd1,2'd0,3'd0,2'd1,0),
        F_BNE | F_ASA | F_ASB | F_AOP | F_PCS);

    instr(6'h04, 6'h00, 1'b1, 1'b0, 2);
    chk("beq", S_BRANCH_EQ, E_PCC, v(0,0,1,2'd0,3'd1,2'd0,3'd0,2'd1,0),
        F_BNE | F_ASA | F_ASB | F_AOP | F_PCS);

    instr(6'h03, 6'h00, 1'b0, 1'b0, 2);
    chk("jal", S_JAL, E_PCW | E_RW, v(0,0,0,2'd0,3'd0,2'd2,3'd2,2'd2,0), F_RD | F_M2R | F_PCS);

    instr(6'h00, 6'h20, 1'b0, 1'b0, 2);
    chk("exec_add", S_EXEC_ADD, '0, v(0,0,1,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    chk("wb_r", S_WB_R, E_RW, v(0,0,0,2'd0,3'd0,2'd1,3'd0,2'd0,0), F_RD | F_M2R);

    instr(6'h08, 6'h00, 1'b0, 1'b1, 2);
    chk("exec_addi", S_EXEC_I, '0, v(0,0,1,2'd2,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    chk("addi_exc", S_EXC_OVF, E_PCW | E_EPC, v(0,0,0,2'd0,3'd0,2'd0,3'd0,2'd3,1), F_PCS | F_EXC);

    instr(6'h00, 6'h25, 1'b0, 1'b0, 2);
    chk("exc_badfunct", S_EXC_OPC, E_PCW | E_EPC, v(0,0,0,2'd0,3'd0,2'd0,3'd0,2'd3,0), F_PCS | F_EXC);

    instr(6'h00, 6'h08, 1'b0, 1'b0, 2);
    chk("jr", S_JR, E_PCW, v(0,0,1,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_PCS);

    instr(6'h0F, 6'h00, 1'b0, 1'b0, 2);
    chk("lui", S_LUI, E_RW, v(0,0,0,2'd0,3'd0,2'd0,3'd3,2'd0,0), F_M2R);
    fetch(2);

    reset1 = 1'b1; use3 = 1'b1;
    chk("in_reset3", S_RESET, '0, '0, F_ALL);
    @(posedge clock); #1 reset3 = 1'b0;
    chk("rst3_cycle0", S_RESET, E_RW, v(0,0,0,2'd0,3'd0,2'd3,3'd4,2'd0,0), F_RD | F_M2R);

    instr(6'h2B, 6'h00, 1'b0, 1'b0, 4);
    chk("addr_sw", S_ADDR_SW, '0, v(0,0,1,2'd2,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    for (int i = 0; i < 4; i++)
      chk("mem_wr", S_MEM_WR, E_MW, v(0,1,0,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_IORD);

    instr(6'h23, 6'h00, 1'b0, 1'b0, 4);
    chk("addr_lw", S_ADDR_LW, '0, v(0,0,1,2'd2,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    for (int i = 0; i < 4; i++)
      chk("mem_rd", S_MEM_RD, '0, v(0,1,0,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_IORD);
    chk("wb_lw", S_WB_LW, E_RW, v(0,0,0,2'd0,3'd0,2'd0,3'd1,2'd0,0), F_RD | F_M2R);

    instr(6'h2B, 6'h00, 1'b0, 1'b0, 4);
    chk("addr_sw2", S_ADDR_SW, '0, v(0,0,1,2'd2,3'd0,2'd0,3'd0,2'd0,0), F_ASA | F_ASB | F_AOP);
    chk("mem_wr_c0", S_MEM_WR, E_MW, v(0,1,0,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_IORD);
    chk("mem_wr_c1", S_MEM_WR, E_MW, v(0,1,0,2'd0,3'd0,2'd0,3'd0,2'd0,0), F_IORD);
    #1 reset3 = 1'b1;
    #1;
    push("rst_async", S_RESET, '0, '0, F_ALL);
    compare_front();
    @(posedge clock); #1 reset3 = 1'b0;
    chk("rst3_again", S_RESET, E_RW, v(0,0,0,2'd0,3'd0,2'd3,3'd4,2'd0,0), F_RD | F_M2R);
    fetch(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
